// File: rtl/kernel3_gmem_c_m_axi_wr_arbiter_if.sv
// Bundle of the requester-side, AW-side and FIFO-push-side signals of the
// gmem_C write-burst arbiter.
//
// Handshake rule for every valid/ready pair carried here: a transfer happens
// on a rising clock edge where valid and ready are both high and clk_en is high.
// The arbiter's ready/grant outputs are combinational and may depend on the
// partner's valid in the same cycle.
//
// master : the arbiter (drives req_ready, wdata_ready, aw_*, fifo_write/din, busy, dbg_*)
// slave  : requesters + AW sink + data FIFO (the arbiter's environment)
interface kernel3_gmem_c_m_axi_wr_arbiter_if #(
  parameter int NUM_REQ    = 4,
  parameter int ID_WIDTH   = 2,
  parameter int ADDR_WIDTH = 64,
  parameter int LEN_WIDTH  = 8,
  parameter int DATA_WIDTH = 32
);
  logic [NUM_REQ-1:0]            req_valid;
  logic [NUM_REQ-1:0]            req_ready;
  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr;
  logic [NUM_REQ*LEN_WIDTH-1:0]  req_len;
  logic [NUM_REQ-1:0]            wdata_valid;
  logic [NUM_REQ-1:0]            wdata_ready;
  logic [NUM_REQ*DATA_WIDTH-1:0] wdata;
  logic                          aw_valid;
  logic                          aw_ready;
  logic [ADDR_WIDTH-1:0]         aw_addr;
  logic [LEN_WIDTH-1:0]          aw_len;
  logic [ID_WIDTH-1:0]           aw_id;
  logic                          fifo_full_n;
  logic                          fifo_write;
  logic [DATA_WIDTH-1:0]         fifo_din;
  logic                          busy;
  logic [1:0]                    dbg_state;     // 0=IDLE 1=ADDR 2=DATA
  logic [LEN_WIDTH-1:0]          dbg_beat_cnt;  // remaining beats minus one

  modport master (
    input  req_valid, req_addr, req_len, wdata_valid, wdata, aw_ready, fifo_full_n,
    output req_ready, wdata_ready, aw_valid, aw_addr, aw_len, aw_id,
           fifo_write, fifo_din, busy, dbg_state, dbg_beat_cnt
  );

  modport slave (
    output req_valid, req_addr, req_len, wdata_valid, wdata, aw_ready, fifo_full_n,
    input  req_ready, wdata_ready, aw_valid, aw_addr, aw_len, aw_id,
           fifo_write, fifo_din, busy, dbg_state, dbg_beat_cnt
  );
endinterface

// File: rtl/kernel3_gmem_c_m_axi_wr_arbiter.sv
// Round-robin write-burst arbiter sharing one gmem_C AXI write path between
// NUM_REQ requesters. One requester is granted per burst: its address/length
// go out on AW, then its data beats are pushed into the shared write-data FIFO.
// The grant is held until the last beat, after which priority rotates so the
// requester just served becomes lowest priority.
//
// Ports:
//   clk     : clock
//   reset   : asynchronous, active-high reset
//   clk_en  : clock enable; low freezes every register and blocks all handshakes
//   bus     : master side of kernel3_gmem_c_m_axi_wr_arbiter_if
//             (requests, per-requester data, AW channel, FIFO push, busy, debug state)
module kernel3_gmem_c_m_axi_wr_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int ID_WIDTH   = 2,
  parameter int ADDR_WIDTH = 64,
  parameter int LEN_WIDTH  = 8,
  parameter int DATA_WIDTH = 32
) (
  input  logic clk,
  input  logic reset,
  input  logic clk_en,
  kernel3_gmem_c_m_axi_wr_arbiter_if.master bus
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_DATA = 2'd2
  } state_t;

  state_t                state_q,    state_d;
  logic [ID_WIDTH-1:0]   rr_ptr_q,   rr_ptr_d;
  logic [LEN_WIDTH-1:0]  beat_cnt_q, beat_cnt_d;
  logic [ADDR_WIDTH-1:0] addr_q,     addr_d;
  logic [LEN_WIDTH-1:0]  len_q,      len_d;
  logic [ID_WIDTH-1:0]   id_q,       id_d;

  // Arbitration: first requester found scanning from rr_ptr+1 upward (mod NUM_REQ).
  logic any_req;
  int   win;
  int   scan_idx;

  always_comb begin
    any_req  = 1'b0;
    win      = 0;
    scan_idx = 0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      scan_idx = (int'(rr_ptr_q) + k) % NUM_REQ;
      if (!any_req && bus.req_valid[scan_idx]) begin
        any_req = 1'b1;
        win     = scan_idx;
      end
    end
  end

  logic [NUM_REQ-1:0]    req_ready_c;
  logic [NUM_REQ-1:0]    wdata_ready_c;
  logic                  aw_valid_c;
  logic                  fifo_write_c;
  logic [DATA_WIDTH-1:0] fifo_din_c;
  int                    gi;

  always_comb begin
    state_d       = state_q;
    rr_ptr_d      = rr_ptr_q;
    beat_cnt_d    = beat_cnt_q;
    addr_d        = addr_q;
    len_d         = len_q;
    id_d          = id_q;
    req_ready_c   = '0;
    wdata_ready_c = '0;
    aw_valid_c    = 1'b0;
    fifo_write_c  = 1'b0;
    fifo_din_c    = '0;
    gi            = int'(id_q);

    case (state_q)
      ST_IDLE: begin
        if (clk_en && any_req) begin
          req_ready_c[win] = 1'b1;
          addr_d  = bus.req_addr[win*ADDR_WIDTH +: ADDR_WIDTH];
          len_d   = bus.req_len[win*LEN_WIDTH +: LEN_WIDTH];
          id_d    = ID_WIDTH'(win);
          state_d = ST_ADDR;
        end
      end

      ST_ADDR: begin
        aw_valid_c = clk_en;
        if (clk_en && bus.aw_ready) begin
          beat_cnt_d = len_q;
          state_d    = ST_DATA;
        end
      end

      ST_DATA: begin
        if (gi < NUM_REQ) begin
          fifo_din_c        = bus.wdata[gi*DATA_WIDTH +: DATA_WIDTH];
          wdata_ready_c[gi] = clk_en & bus.fifo_full_n;
          fifo_write_c      = clk_en & bus.fifo_full_n & bus.wdata_valid[gi];
        end
        if (fifo_write_c) begin
          // beat_cnt holds remaining beats minus one, so a push at zero is the
          // last beat; len=all-ones therefore yields 2^LEN_WIDTH beats.
          if (beat_cnt_q == '0) begin
            rr_ptr_d = id_q;
            state_d  = ST_IDLE;
          end else begin
            beat_cnt_d = beat_cnt_q - LEN_WIDTH'(1);
          end
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      rr_ptr_q   <= ID_WIDTH'(NUM_REQ - 1);  // requester 0 wins first
      beat_cnt_q <= '0;
      addr_q     <= '0;
      len_q      <= '0;
      id_q       <= '0;
    end else if (clk_en) begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      beat_cnt_q <= beat_cnt_d;
      addr_q     <= addr_d;
      len_q      <= len_d;
      id_q       <= id_d;
    end
  end

  assign bus.req_ready    = req_ready_c;
  assign bus.wdata_ready  = wdata_ready_c;
  assign bus.aw_valid     = aw_valid_c;
  assign bus.aw_addr      = addr_q;
  assign bus.aw_len       = len_q;
  assign bus.aw_id        = id_q;
  assign bus.fifo_write   = fifo_write_c;
  assign bus.fifo_din     = fifo_din_c;
  assign bus.busy         = (state_q != ST_IDLE);
  assign bus.dbg_state    = state_q;
  assign bus.dbg_beat_cnt = beat_cnt_q;

endmodule

// File: tb/tb_kernel3_gmem_c_m_axi_wr_arbiter.sv
module tb_kernel3_gmem_c_m_axi_wr_arbiter;
  localparam int NR = 4;
  localparam int IW = 2;
  localparam int AW = 64;
  localparam int LW = 8;
  localparam int DW = 32;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  logic clk_en;
  always #5 clk = ~clk;

  // ---------------- DUT inputs (driven by the single stimulus process) ----
  logic [NR-1:0]    req_valid;
  logic [NR*AW-1:0] req_addr;
  logic [NR*LW-1:0] req_len;
  logic [NR-1:0]    wdata_valid;
  logic [NR*DW-1:0] wdata;
  logic             aw_ready;
  logic             fifo_full_n;

  kernel3_gmem_c_m_axi_wr_arbiter_if #(
    .NUM_REQ(NR), .ID_WIDTH(IW), .ADDR_WIDTH(AW), .LEN_WIDTH(LW), .DATA_WIDTH(DW)
  ) bus ();

  assign bus.req_valid   = req_valid;
  assign bus.req_addr    = req_addr;
  assign bus.req_len     = req_len;
  assign bus.wdata_valid = wdata_valid;
  assign bus.wdata       = wdata;
  assign bus.aw_ready    = aw_ready;
  assign bus.fifo_full_n = fifo_full_n;

  kernel3_gmem_c_m_axi_wr_arbiter #(
    .NUM_REQ(NR), .ID_WIDTH(IW), .ADDR_WIDTH(AW), .LEN_WIDTH(LW), .DATA_WIDTH(DW)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .clk_en (clk_en),
    .bus    (bus)
  );

  // ---------------- scoreboard ----------------
  logic [IW+AW+LW-1:0] exp_aw_q[$];  // {id, addr, len} in expected grant order
  logic [DW-1:0]       exp_q[$];     // expected FIFO pushes in order
  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] word(input int r, input int tag, input int k);
    return {8'(r), 8'(tag), 16'(k)};
  endfunction

  // ---------------- requester / sink model state ----------------
  int beat[NR], blen[NR], btag[NR], again[NR];
  bit active[NR];
  bit gappy;
  int aw_hold, full_hold, full_trigger;
  int test_pushes;
  int cur_id;
  logic [LW-1:0] frozen_beat;
  bit aw_hold_seen;
  logic [AW-1:0] sv_addr;
  logic [LW-1:0] sv_len;
  logic [IW-1:0] sv_id;

  task automatic clear_agents();
    for (int r = 0; r < NR; r++) begin
      beat[r] = 0; blen[r] = 0; btag[r] = 0; again[r] = 0; active[r] = 0;
    end
    req_valid = '0; req_addr = '0; req_len = '0;
    wdata_valid = '0; wdata = '0;
    aw_hold = 0; full_hold = 0; full_trigger = -1;
    aw_ready = 1'b1; fifo_full_n = 1'b1;
    gappy = 0; aw_hold_seen = 0;
  endtask

  task automatic post(input int r, input logic [AW-1:0] addr, input int len, input int tag);
    req_valid[r] = 1'b1;
    req_addr[r*AW +: AW] = addr;
    req_len[r*LW +: LW]  = LW'(len);
    blen[r] = len; btag[r] = tag; beat[r] = 0; active[r] = 0;
    wdata[r*DW +: DW] = word(r, tag, 0);
  endtask

  task automatic expect_burst(input int r, input logic [AW-1:0] addr, input int len, input int tag);
    exp_aw_q.push_back({IW'(r), addr, LW'(len)});
    for (int k = 0; k <= len; k++) exp_q.push_back(word(r, tag, k));
  endtask

  // Checks everything visible at the negedge of the current cycle.
  task automatic monitor();
    logic [IW+AW+LW-1:0] e;
    if (bus.req_ready != '0)
      check("req_ready_onehot", 64'($onehot(bus.req_ready)), 64'd1);
    if (bus.aw_valid && bus.aw_ready) begin
      if (exp_aw_q.size() == 0) check("aw_unexpected", 64'(bus.aw_valid), 64'd0);
      else begin
        e = exp_aw_q.pop_front();
        check("aw_id",   64'(bus.aw_id),  64'(e[IW+AW+LW-1 -: IW]));
        check("aw_addr", bus.aw_addr,     e[AW+LW-1 -: AW]);
        check("aw_len",  64'(bus.aw_len), 64'(e[LW-1:0]));
        cur_id = int'(e[IW+AW+LW-1 -: IW]);
      end
    end
    if (bus.aw_valid && !bus.aw_ready) begin
      if (aw_hold_seen) begin
        check("aw_hold_addr", bus.aw_addr,     sv_addr);
        check("aw_hold_len",  64'(bus.aw_len), 64'(sv_len));
        check("aw_hold_id",   64'(bus.aw_id),  64'(sv_id));
      end
      aw_hold_seen = 1;
      sv_addr = bus.aw_addr; sv_len = bus.aw_len; sv_id = bus.aw_id;
      check("aw_hold_wready", 64'(bus.wdata_ready), 64'd0);
    end else begin
      aw_hold_seen = 0;
    end
    if (bus.wdata_ready != '0)
      check("wready_other", 64'(bus.wdata_ready & ~(4'b0001 << cur_id)), 64'd0);
    if (!fifo_full_n && bus.busy)
      check("full_no_write", 64'(bus.fifo_write), 64'd0);
    if (!clk_en) begin
      check("clken_outputs", 64'({bus.req_ready, bus.wdata_ready, bus.aw_valid, bus.fifo_write}), 64'd0);
      check("clken_beat_frozen", 64'(bus.dbg_beat_cnt), 64'(frozen_beat));
    end
    if (bus.fifo_write) begin
      test_pushes++;
      if (exp_q.size() == 0) check("fifo_unexpected", 64'(bus.fifo_write), 64'd0);
      else check("fifo_din", 64'(bus.fifo_din), 64'(exp_q.pop_front()));
    end
  endtask

  // One clock cycle: sample at negedge, update stimulus 1ns after posedge.
  task automatic tick();
    logic [NR-1:0] gr, wa;
    bit aw_seen;
    @(negedge clk);
    monitor();
    gr = bus.req_ready & req_valid;
    wa = bus.wdata_ready & wdata_valid;
    aw_seen = bus.aw_valid;
    @(posedge clk);
    #1;
    if (aw_hold > 0 && aw_seen) aw_hold--;
    aw_ready = (aw_hold == 0);
    if (full_hold > 0) full_hold--;
    if (full_trigger >= 0 && test_pushes == full_trigger) begin
      full_hold = 3;
      full_trigger = -1;
    end
    fifo_full_n = (full_hold == 0);
    for (int r = 0; r < NR; r++) begin
      if (gr[r]) begin
        req_valid[r] = 1'b0;
        active[r] = 1;
      end
      if (wa[r]) begin
        beat[r]++;
        if (beat[r] > blen[r]) begin
          active[r] = 0;
          if (again[r] > 0) begin
            again[r]--;
            btag[r]++;
            beat[r] = 0;
            req_valid[r] = 1'b1;
          end
        end
      end
      wdata_valid[r] = active[r] && (!gappy || $urandom_range(0, 3) != 0);
      wdata[r*DW +: DW] = word(r, btag[r], beat[r]);
    end
  endtask

  task automatic wait_done(input int budget);
    for (int i = 0; i < budget; i++) begin
      if (exp_aw_q.size() == 0 && exp_q.size() == 0 && !bus.busy && req_valid == '0) break;
      tick();
    end
    check("done_aw_left",   64'(exp_aw_q.size()), 64'd0);
    check("done_data_left", 64'(exp_q.size()),    64'd0);
    check("done_busy",      64'(bus.busy),        64'd0);
  endtask

  task automatic reset_dut();
    reset = 1'b1;
    clear_agents();
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    cur_id = 0; test_pushes = 0; frozen_beat = '0;
    clk_en = 1'b1;
    reset = 1'b1;
    clear_agents();
    repeat (2) @(posedge clk);
    #1;
    // reset state
    check("rst_busy",     64'(bus.busy),         64'd0);
    check("rst_state",    64'(bus.dbg_state),    64'd0);
    check("rst_beat_cnt", 64'(bus.dbg_beat_cnt), 64'd0);
    check("rst_aw",       64'({bus.aw_valid, bus.aw_id, bus.aw_len}), 64'd0);
    check("rst_aw_addr",  bus.aw_addr,           64'd0);
    reset = 1'b0;

    // 1: requesters 0 and 2, len=1 each -> 0 then 2
    post(0, 64'h1000, 1, 1);
    post(2, 64'h2000, 1, 1);
    expect_burst(0, 64'h1000, 1, 1);
    expect_burst(2, 64'h2000, 1, 1);
    wait_done(200);

    // 2: all four requesting continuously, len=0 -> 0,1,2,3,0
    reset_dut();
    gappy = 1;
    for (int r = 0; r < NR; r++) post(r, 64'h3000 + 64'(r * 64), 0, 2);
    again[0] = 1;
    for (int r = 0; r < NR; r++) expect_burst(r, 64'h3000 + 64'(r * 64), 0, 2);
    expect_burst(0, 64'h3000, 0, 3);
    wait_done(300);
    gappy = 0;

    // 3: FIFO full for 3 cycles after beat 1 of a 4-beat burst
    test_pushes = 0;
    full_trigger = 1;
    post(2, 64'hDEAD_BEEF_0000_0040, 3, 4);
    expect_burst(2, 64'hDEAD_BEEF_0000_0040, 3, 4);
    wait_done(200);
    check("t3_pushes", 64'(test_pushes), 64'd4);

    // 4: aw_ready held low for 5 ADDR cycles
    aw_hold = 5;
    aw_ready = 1'b0;
    post(3, 64'hFFFF_0000_1234_5678, 2, 5);
    expect_burst(3, 64'hFFFF_0000_1234_5678, 2, 5);
    wait_done(200);

    // 7: len=all-ones gives 256 beats
    test_pushes = 0;
    gappy = 1;
    post(1, 64'h8000, 255, 7);
    expect_burst(1, 64'h8000, 255, 7);
    wait_done(1000);
    check("t7_pushes", 64'(test_pushes), 64'd256);
    gappy = 0;

    // 6: clk_en low for 2 cycles mid-burst (ends with requester 0 served last)
    test_pushes = 0;
    post(0, 64'h9000, 3, 6);
    expect_burst(0, 64'h9000, 3, 6);
    for (int i = 0; i < 50 && test_pushes < 1; i++) tick();
    check("t6_first_push", 64'(test_pushes), 64'd1);
    frozen_beat = bus.dbg_beat_cnt;
    clk_en = 1'b0;
    tick();
    tick();
    clk_en = 1'b1;
    wait_done(200);
    check("t6_pushes", 64'(test_pushes), 64'd4);

    // 5: reset in DATA after 2 of 8 beats; priority restarts at requester 0
    test_pushes = 0;
    post(1, 64'hA000, 7, 8);
    expect_burst(1, 64'hA000, 7, 8);
    for (int i = 0; i < 50 && test_pushes < 2; i++) tick();
    check("t5_two_pushes", 64'(test_pushes), 64'd2);
    reset = 1'b1;
    #1;
    check("t5_rst_busy",   64'(bus.busy),      64'd0);
    check("t5_rst_state",  64'(bus.dbg_state), 64'd0);
    check("t5_rst_hs",     64'({bus.req_ready, bus.wdata_ready, bus.aw_valid, bus.fifo_write}), 64'd0);
    check("t5_rst_din",    64'(bus.fifo_din),  64'd0);
    exp_aw_q.delete();
    exp_q.delete();
    reset_dut();
    post(1, 64'hB100, 1, 9);
    post(0, 64'hB000, 1, 9);
    expect_burst(0, 64'hB000, 1, 9);
    expect_burst(1, 64'hB100, 1, 9);
    wait_done(200);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
